// File: rtl/cond_unit_it.sv
// Conditional-execution unit: ARM condition decode over banked NZCV flags, with
// a Thumb-style IT block sequencer that overrides the per-instruction condition.
module cond_unit_it #(
  parameter int unsigned NBANK = 2,
  parameter int unsigned BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Valid,
  input  logic          Stall,
  input  logic          Flush,
  input  logic [BW-1:0] Bank,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          ItStart,
  input  logic [3:0]    ItCond,
  input  logic [2:0]    ItLen,
  input  logic [3:0]    ItThen,
  output logic          PCSrc,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          CondEx,
  output logic [3:0]    Flags,
  output logic          ItActive,
  output logic          ItErr
);

  typedef enum logic {StIdle, StActive} state_e;

  localparam logic [BW:0] NBankW = NBANK[BW:0];

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  rem_q, rem_d;
  logic [3:0]  it_cond_q, it_cond_d;
  logic [3:0]  it_then_q, it_then_d;
  logic        err_q, err_d;
  logic [3:0]  bank_q [NBANK];
  logic [3:0]  bank_d [NBANK];

  logic          go, active, opener, len_ok, cond_ok, exec;
  logic [BW-1:0] bank_sel;
  logic [3:0]    eff_cond, flags_sel;

  // Low bit of the condition inverts the base test; 111x gives AL / never.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  always_comb begin
    bank_sel  = ({1'b0, Bank} < NBankW) ? Bank : '0;
    flags_sel = bank_q[bank_sel];
    go        = reset & Valid & ~Stall & ~Flush;
    active    = (state_q == StActive);
    opener    = go & ItStart & ~active;
    len_ok    = (ItLen != 3'd0) && (ItLen <= 3'd4);

    eff_cond = Cond;
    if (active) begin
      if (it_then_q[idx_q] || it_cond_q == 4'hE) begin
        eff_cond = it_cond_q;
      end else begin
        eff_cond = {it_cond_q[3:1], ~it_cond_q[0]};
      end
    end

    cond_ok  = cond_pass(eff_cond, flags_sel);
    // The IT instruction itself always "passes" but never writes anything.
    CondEx   = go & (opener | cond_ok);
    exec     = CondEx & ~opener;
    PCSrc    = PCS & exec;
    RegWrite = RegW & exec;
    MemWrite = MemW & exec;
    Flags    = flags_sel;
    ItActive = active;
    ItErr    = err_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    it_cond_d = it_cond_q;
    it_then_d = it_then_q;
    err_d     = go & ItStart & (active | ~len_ok);
    bank_d    = bank_q;

    if (Flush) begin
      state_d = StIdle;
      idx_d   = '0;
      rem_d   = '0;
    end else if (go) begin
      if (active) begin
        idx_d = idx_q + 2'd1;
        rem_d = rem_q - 3'd1;
        if (rem_q == 3'd1 || PCSrc) begin
          state_d = StIdle;
        end
      end else if (opener && len_ok) begin
        state_d   = StActive;
        idx_d     = '0;
        rem_d     = ItLen;
        it_cond_d = ItCond;
        it_then_d = ItThen;
      end
    end

    for (int unsigned i = 0; i < NBANK; i++) begin
      if (exec && bank_sel == i[BW-1:0]) begin
        if (FlagW[1]) bank_d[i][3:2] = ALUFlags[3:2];
        if (FlagW[0]) bank_d[i][1:0] = ALUFlags[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rem_q     <= '0;
      it_cond_q <= '0;
      it_then_q <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NBANK; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      it_cond_q <= it_cond_d;
      it_then_q <= it_then_d;
      err_q     <= err_d;
      for (int unsigned i = 0; i < NBANK; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

endmodule

// File: doc/cond_unit_it.md
COND_UNIT_IT -- requirements
Module: cond_unit_it

Interface
REQ-001 Parameter NBANK, default 2, number of independent NZCV flag banks (>=1).
REQ-002 Parameter BW = max(1, $clog2(NBANK)), derived, width of the Bank port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 Valid  input  1  instruction present this cycle.
REQ-006 Stall  input  1  hold all state; gate all enables.
REQ-007 Flush  input  1  discard current instruction; abort any IT block.
REQ-008 Bank  input  BW  flag bank used for evaluation and update; values >= NBANK select bank 0.
REQ-009 Cond  input  4  ARM condition field (NZCV = Flags[3:0]).
REQ-010 ALUFlags  input  4  NZCV from ALU.
REQ-011 FlagW  input  2  bit1 enables NZ update, bit0 enables CV update.
REQ-012 PCS, RegW, MemW  input  1 each  unconditional branch/reg-write/mem-write requests.
REQ-013 ItStart  input  1  current instruction opens an IT block.
REQ-014 ItCond  input  4  base condition of the IT block.
REQ-015 ItLen  input  3  block length, legal 1..4.
REQ-016 ItThen  input  4  bit k=1: k-th instruction uses ItCond; 0: inverted ItCond.
REQ-017 PCSrc, RegWrite, MemWrite  output  1 each  gated requests.
REQ-018 CondEx  output  1  effective condition passed.
REQ-019 Flags  output  4  registered NZCV of selected bank.
REQ-020 ItActive  output  1  registered; IT block in progress.
REQ-021 ItErr  output  1  registered one-cycle pulse on illegal IT use.

Function
REQ-022 Go = Valid & ~Stall & ~Flush; CondEx, PCSrc, RegWrite, MemWrite SHALL be 0 whenever Go=0.
REQ-023 Condition decode SHALL follow ARM: 0000 EQ Z, 0001 NE, 0010 CS C, 0011 CC, 0100 MI N, 0101 PL, 0110 VS V, 0111 VC, 1000 HI C&~Z, 1001 LS, 1010 GE N==V, 1011 LT, 1100 GT ~Z&(N==V), 1101 LE, 1110 AL true, 1111 never (false).
REQ-024 Evaluation SHALL use the registered flags of the selected bank (pre-update value); no same-cycle ALUFlags bypass.
REQ-025 Effective condition SHALL be Cond in IDLE; in ACTIVE it SHALL be ItCond if ItThen[idx]=1, else ItCond with bit0 inverted, except ItCond=1110 stays 1110.
REQ-026 PCSrc=PCS&CondEx, RegWrite=RegW&CondEx, MemWrite=MemW&CondEx (combinational).
REQ-027 On Go & CondEx, bank[Bank][3:2]<=ALUFlags[3:2] if FlagW[1]; bank[Bank][1:0]<=ALUFlags[1:0] if FlagW[0]; other banks unchanged.
REQ-028 IT FSM states IDLE, ACTIVE; counter idx (2 bits) and remaining count rem (3 bits).
REQ-029 IDLE->ACTIVE when Go & ItStart & ItLen in 1..4: latch ItCond/ItThen, idx<=0, rem<=ItLen; the IT instruction itself SHALL assert CondEx=1 with PCSrc/RegWrite/MemWrite=0 and no flag update.
REQ-030 Go & ItStart with ItLen in {0,5,6,7} in IDLE: no state change, outputs as REQ-029 except FSM stays IDLE, ItErr pulses next cycle.
REQ-031 In ACTIVE each Go instruction SHALL consume one slot: idx<=idx+1, rem<=rem-1; rem reaching 0 returns to IDLE same edge.
REQ-032 In ACTIVE, ItStart SHALL be ignored as an IT opener (instruction handled as a normal predicated op) and ItErr pulses.
REQ-033 In ACTIVE, PCSrc=1 SHALL end the block (->IDLE) regardless of rem.
REQ-034 Flush SHALL force IDLE at the next edge with no flag update; Stall or Valid=0 SHALL hold FSM, idx, rem, banks.
REQ-035 Flush has priority over Stall; Stall over Valid.
REQ-036 Flags output SHALL reflect bank[Bank] registered value combinationally selected by Bank.

Reset
REQ-037 reset low SHALL clear all banks to 0000, FSM to IDLE, idx=0, rem=0, ItActive=0, ItErr=0, asynchronously.
REQ-038 Outputs during reset: CondEx, PCSrc, RegWrite, MemWrite SHALL be 0.
REQ-039 Reset asserted mid-IT-block SHALL abandon the block; first post-reset instruction uses Cond.

Verification
REQ-040 Reset, Bank=0, ALUFlags=0100, FlagW=11, Cond=1110 -> next cycle Flags=0100; then Cond=0000 RegW=1 -> RegWrite=1; Cond=0001 -> RegWrite=0.
REQ-041 NBANK=2: write 1000 into bank1 (Bank=1), Bank=0 Cond=0100 (MI) -> CondEx=0; Bank=1 same -> CondEx=1.
REQ-042 Flags Z=1, ItStart ItCond=0000 ItLen=3 ItThen=0101: three RegW=1 instructions -> RegWrite 1,0,1; ItActive 1 for three cycles then 0.
REQ-043 IT block ItLen=4, Stall high 2 cycles after slot 1 -> idx/rem frozen, all enables 0 during stall, block completes after 4 Go instructions.
REQ-044 ItLen=4 ItCond=1110, slot 2 PCS=1 -> PCSrc=1, ItActive=0 next cycle; ItStart with ItLen=0 -> ItErr=1 one cycle.
REQ-045 reset low during slot 2 of IT block -> ItActive=0, Flags=0000 immediately; next instruction Cond=1111 -> CondEx=0.
